// File: rtl/sfx_pkg.sv
// Shared sound-effect definitions: effect ids, FSM states, note record and 100 MHz pitch periods.
// Pure declarations: no latency, no flow control.
package sfx_pkg;

  localparam int SFX_UP    = 0;
  localparam int SFX_DOWN  = 1;
  localparam int SFX_SCORE = 2;
  localparam int SFX_CRASH = 3;

  localparam int NOTE_PER_W = 20;
  localparam int NOTE_DUR_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY
  } sfx_state_t;

  typedef struct packed {
    logic [NOTE_PER_W-1:0] period;
    logic [NOTE_DUR_W-1:0] dur;
    logic                  last;
  } note_t;

  localparam logic [NOTE_PER_W-1:0] REST = '0;

  // Tone periods in 100 MHz clock cycles.
  localparam logic [NOTE_PER_W-1:0] P_C4 = 20'd382219;
  localparam logic [NOTE_PER_W-1:0] P_E4 = 20'd303370;
  localparam logic [NOTE_PER_W-1:0] P_G4 = 20'd255102;
  localparam logic [NOTE_PER_W-1:0] P_A4 = 20'd227273;
  localparam logic [NOTE_PER_W-1:0] P_C5 = 20'd191113;
  localparam logic [NOTE_PER_W-1:0] P_E5 = 20'd151688;
  localparam logic [NOTE_PER_W-1:0] P_G5 = 20'd127553;
  localparam logic [NOTE_PER_W-1:0] P_C6 = 20'd95557;

  localparam logic [NOTE_DUR_W-1:0] D_SHORT = 24'd5_000_000;
  localparam logic [NOTE_DUR_W-1:0] D_LONG  = 24'd15_000_000;

  function automatic note_t mk_note(input logic [NOTE_PER_W-1:0] p,
                                    input logic [NOTE_DUR_W-1:0] d,
                                    input logic                  l);
    note_t n;
    n.period = p;
    n.dur    = d;
    n.last   = l;
    return n;
  endfunction

endpackage

// File: rtl/sfx_note_rom.sv
// Combinational note table: (effect, note index) -> note record; unused slots are a last-flagged rest.
// Zero latency, no flow control.
module sfx_note_rom import sfx_pkg::*; #(
  parameter int SFX_W  = 2,
  parameter int NOTE_W = 4
) (
  input  logic [SFX_W-1:0]  sfx,
  input  logic [NOTE_W-1:0] note_idx,
  output note_t             note
);

  always_comb begin
    note = mk_note(REST, 24'd1, 1'b1);
    case (int'(sfx))
      SFX_UP: begin
        case (int'(note_idx))
          0:       note = mk_note(20'd10, 24'd40, 1'b0);
          1:       note = mk_note(20'd20, 24'd40, 1'b1);
          default: ;
        endcase
      end
      SFX_DOWN: begin
        case (int'(note_idx))
          0:       note = mk_note(P_G4, D_SHORT, 1'b0);
          1:       note = mk_note(P_E4, D_SHORT, 1'b0);
          2:       note = mk_note(P_C4, D_LONG,  1'b1);
          default: ;
        endcase
      end
      SFX_SCORE: begin
        case (int'(note_idx))
          0:       note = mk_note(P_C5, D_SHORT, 1'b0);
          1:       note = mk_note(P_E5, D_SHORT, 1'b0);
          2:       note = mk_note(P_G5, D_SHORT, 1'b0);
          3:       note = mk_note(REST, D_SHORT, 1'b0);
          4:       note = mk_note(P_C6, D_LONG,  1'b1);
          default: ;
        endcase
      end
      SFX_CRASH: begin
        case (int'(note_idx))
          0:       note = mk_note(20'd4,  24'd16, 1'b0);
          1:       note = mk_note(REST,   24'd16, 1'b0);
          2:       note = mk_note(20'd8,  24'd16, 1'b1);
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // P_A4 is kept in the package for future tables.
  logic unused_pitch;
  assign unused_pitch = ^P_A4;

endmodule

// File: rtl/sfx_sequencer.sv
// Table-driven piezo effect sequencer with rising-edge triggers, priority pre-emption and enable gating.
// Trigger edge -> busy next cycle, first tone cycle one later; SFX_QUEUE_EN adds a one-deep pending slot.
module sfx_sequencer import sfx_pkg::*; #(
  parameter  int NUM_SFX   = 4,
  parameter  int MAX_NOTES = 16,
  parameter  int PERIOD_W  = 20,
  parameter  int DUR_W     = 24,
  localparam int SFX_W     = (NUM_SFX > 1) ? $clog2(NUM_SFX) : 1,
  localparam int NOTE_W    = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_SFX-1:0] trig,
  output logic               beep,
  output logic               busy,
  output logic [SFX_W-1:0]   cur_sfx,
  output logic [NOTE_W-1:0]  note_idx
);

  sfx_state_t          state, state_nxt;
  logic [NUM_SFX-1:0]  trig_prev, rise;
  logic                any_rise;
  logic [SFX_W-1:0]    win, cur_nxt;
  logic [NOTE_W-1:0]   idx_nxt, idx_inc;
  logic [PERIOD_W-1:0] per_cnt, per_nxt, per_wrap, period, period_nx;
  logic [DUR_W-1:0]    dur_cnt, dur_nxt, dur, dur_last;
  logic                beep_nxt, note_end, eff_end;
  note_t               note_cur, note_nx;

`ifdef SFX_QUEUE_EN
  logic                pend_vld, pend_vld_nxt, drop;
  logic [SFX_W-1:0]    pend_idx, pend_idx_nxt;
`endif

  function automatic logic tone(input logic [PERIOD_W-1:0] ph, input logic [PERIOD_W-1:0] p);
    return (p != '0) && (ph >= (p >> 1));
  endfunction

  assign rise     = trig & ~trig_prev;
  assign any_rise = |rise;
  assign busy     = (state != ST_IDLE);

  always_comb begin
    win = '0;
    for (int i = 0; i < NUM_SFX; i++) begin
      if (rise[i]) win = SFX_W'(i);
    end
  end

  // The second lookup gives the next note's period so beep stays registered across note boundaries.
  assign idx_inc = note_idx + 1'b1;

  sfx_note_rom #(.SFX_W(SFX_W), .NOTE_W(NOTE_W)) u_rom_cur (
    .sfx      (cur_sfx),
    .note_idx (note_idx),
    .note     (note_cur)
  );

  sfx_note_rom #(.SFX_W(SFX_W), .NOTE_W(NOTE_W)) u_rom_nxt (
    .sfx      (cur_sfx),
    .note_idx (idx_inc),
    .note     (note_nx)
  );

  logic unused_nx;
  assign unused_nx = ^{note_nx.dur, note_nx.last};

  assign period    = PERIOD_W'(note_cur.period);
  assign period_nx = PERIOD_W'(note_nx.period);
  assign dur       = DUR_W'(note_cur.dur);
  assign dur_last  = (dur == '0) ? '0 : dur - 1'b1;
  assign note_end  = (dur_cnt >= dur_last);
  assign eff_end   = note_end && (note_cur.last || (note_idx == NOTE_W'(MAX_NOTES - 1)));
  assign per_wrap  = ((period == '0) || (per_cnt >= period - 1'b1)) ? '0 : per_cnt + 1'b1;

`ifdef SFX_QUEUE_EN
  assign drop = any_rise && (win <= cur_sfx) &&
                ((state == ST_LOAD) || ((state == ST_PLAY) && !eff_end));
`endif

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur_sfx;
    idx_nxt   = note_idx;
    per_nxt   = per_cnt;
    dur_nxt   = dur_cnt;
    beep_nxt  = beep;
`ifdef SFX_QUEUE_EN
    pend_vld_nxt = pend_vld;
    pend_idx_nxt = pend_idx;
`endif
    if (!en) begin
      state_nxt = ST_IDLE;
      cur_nxt   = '0;
      idx_nxt   = '0;
      per_nxt   = '0;
      dur_nxt   = '0;
      beep_nxt  = 1'b0;
`ifdef SFX_QUEUE_EN
      pend_vld_nxt = 1'b0;
      pend_idx_nxt = '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          beep_nxt = 1'b0;
          if (any_rise) begin
            state_nxt = ST_LOAD;
            cur_nxt   = win;
            idx_nxt   = '0;
            per_nxt   = '0;
            dur_nxt   = '0;
          end
        end
        ST_LOAD: begin
          if (any_rise && (win > cur_sfx)) begin
            cur_nxt = win;
          end else begin
            state_nxt = ST_PLAY;
            per_nxt   = '0;
            dur_nxt   = '0;
            beep_nxt  = tone('0, period);
          end
        end
        ST_PLAY: begin
          // A rise coinciding with the final cycle always restarts, even at lower priority.
          if (any_rise && ((win > cur_sfx) || eff_end)) begin
            state_nxt = ST_LOAD;
            cur_nxt   = win;
            idx_nxt   = '0;
            per_nxt   = '0;
            dur_nxt   = '0;
            beep_nxt  = 1'b0;
`ifdef SFX_QUEUE_EN
          end else if (eff_end && pend_vld) begin
            state_nxt    = ST_LOAD;
            cur_nxt      = pend_idx;
            idx_nxt      = '0;
            per_nxt      = '0;
            dur_nxt      = '0;
            beep_nxt     = 1'b0;
            pend_vld_nxt = 1'b0;
            pend_idx_nxt = '0;
`endif
          end else if (eff_end) begin
            state_nxt = ST_IDLE;
            cur_nxt   = '0;
            idx_nxt   = '0;
            per_nxt   = '0;
            dur_nxt   = '0;
            beep_nxt  = 1'b0;
          end else if (note_end) begin
            idx_nxt  = idx_inc;
            per_nxt  = '0;
            dur_nxt  = '0;
            beep_nxt = tone('0, period_nx);
          end else begin
            per_nxt  = per_wrap;
            dur_nxt  = dur_cnt + 1'b1;
            beep_nxt = tone(per_wrap, period);
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
`ifdef SFX_QUEUE_EN
      if (drop && (!pend_vld || (win > pend_idx))) begin
        pend_vld_nxt = 1'b1;
        pend_idx_nxt = win;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      trig_prev <= '0;
      cur_sfx   <= '0;
      note_idx  <= '0;
      per_cnt   <= '0;
      dur_cnt   <= '0;
      beep      <= 1'b0;
    end else begin
      state     <= state_nxt;
      trig_prev <= trig;
      cur_sfx   <= cur_nxt;
      note_idx  <= idx_nxt;
      per_cnt   <= per_nxt;
      dur_cnt   <= dur_nxt;
      beep      <= beep_nxt;
    end
  end

`ifdef SFX_QUEUE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld <= 1'b0;
      pend_idx <= '0;
    end else begin
      pend_vld <= pend_vld_nxt;
      pend_idx <= pend_idx_nxt;
    end
  end
`endif

endmodule
